adder_trace_checker: RTL



---
 rtl/adder_trace_pkg.sv | 24 ++
 rtl/trace_tag_pipe.sv | 49 ++++
 rtl/adder_trace_checker.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/adder_trace_pkg.sv
// Shared types and defaults for the adder trace checker.
// Build option: ADDER_CHECK_STOP_ON_FAIL_EN (see adder_trace_checker.sv).
package adder_trace_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_LATENCY = 1;

  // Run-control states of the checker.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // One trace record as produced by the adder stimulus bench.
  typedef struct packed {
    logic [DEF_WIDTH-1:0] x;
    logic [DEF_WIDTH-1:0] y;
    logic [DEF_WIDTH:0]   sum;
  } trace_rec_t;

endpackage

// File: rtl/trace_tag_pipe.sv
// Expected-result tag pipeline: DEPTH stages of {valid, sum, index}.
// A tag pushed at edge t sits in the tail stage after edge t+DEPTH-1, so it
// is compared at edge t+DEPTH. clr drops every valid bit synchronously.
module trace_tag_pipe #(
  parameter int SUM_W = 9,
  parameter int IDX_W = 16,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [SUM_W-1:0] in_sum,
  input  logic [IDX_W-1:0] in_idx,
  output logic             tail_valid,
  output logic [SUM_W-1:0] tail_sum,
  output logic [IDX_W-1:0] tail_idx,
  output logic             busy
);

  logic [DEPTH-1:0] vld;
  logic [SUM_W-1:0] sum_q [DEPTH];
  logic [IDX_W-1:0] idx_q [DEPTH];

  // Valid bits shift every cycle; clear empties the pipe.
  always_ff @(posedge clk) begin
    if (clr) begin
      vld <= '0;
    end else begin
      vld[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) vld[i] <= vld[i-1];
    end
  end

  // Payload shifts alongside; only meaningful where the valid bit is set.
  always_ff @(posedge clk) begin
    sum_q[0] <= in_sum;
    idx_q[0] <= in_idx;
    for (int i = 1; i < DEPTH; i++) begin
      sum_q[i] <= sum_q[i-1];
      idx_q[i] <= idx_q[i-1];
    end
  end

  assign tail_valid = vld[DEPTH-1];
  assign tail_sum   = sum_q[DEPTH-1];
  assign tail_idx   = idx_q[DEPTH-1];
  assign busy       = |vld;

endmodule

// File: rtl/adder_trace_checker.sv
// Replays x,y,sum trace records into a registered adder and checks its
// output against the recorded sum LATENCY cycles later.
// Build option ADDER_CHECK_STOP_ON_FAIL_EN: when defined, the first mismatch
// stops accepting records; in-flight tags are still compared, then DONE.
// Record stream handshake: a record transfers on a rising edge where
// rec_valid && rec_ready; rec_ready is high only in RUN and never depends
// combinationally on rec_valid.
module adder_trace_checker
  import adder_trace_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int LATENCY = DEF_LATENCY,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             rec_valid,
  output logic             rec_ready,
  input  logic             rec_last,
  input  logic [WIDTH-1:0] rec_x,
  input  logic [WIDTH-1:0] rec_y,
  input  logic [WIDTH:0]   rec_sum,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  input  logic [WIDTH:0]   dut_out,
  output logic [CNT_W-1:0] record_count,
  output logic [CNT_W-1:0] mismatch_count,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic             fail_seen,
  output logic             done,
  output logic             pass,
  output state_e           state_dbg
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state, state_nx;
  logic             hs;
  logic             start_run;
  logic             tail_valid;
  logic [WIDTH:0]   tail_sum;
  logic [CNT_W-1:0] tail_idx;
  logic             pipe_busy;
  logic             bad;
  logic [CNT_W-1:0] idx_cnt;

  assign hs        = rec_valid && rec_ready;
  assign start_run = start && ((state == IDLE) || (state == DONE));
  assign bad       = tail_valid && (dut_out != tail_sum);
  assign state_dbg = state;

  trace_tag_pipe #(
    .SUM_W (WIDTH + 1),
    .IDX_W (CNT_W),
    .DEPTH (LATENCY)
  ) u_tag_pipe (
    .clk        (clk),
    .clr        (rst || start_run),
    .in_valid   (hs),
    .in_sum     (rec_sum),
    .in_idx     (idx_cnt),
    .tail_valid (tail_valid),
    .tail_sum   (tail_sum),
    .tail_idx   (tail_idx),
    .busy       (pipe_busy)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and status outputs.
  always_comb begin
    state_nx  = state;
    rec_ready = 1'b0;
    done      = 1'b0;
    pass      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = RUN;
      end
      RUN: begin
        rec_ready = 1'b1;
        if (hs && rec_last) state_nx = DRAIN;
`ifdef ADDER_CHECK_STOP_ON_FAIL_EN
        if (bad) state_nx = DRAIN;
`endif
      end
      DRAIN: begin
        if (!pipe_busy) state_nx = DONE;
      end
      DONE: begin
        done = 1'b1;
        pass = (mismatch_count == '0);
        if (start) state_nx = RUN;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand registers feeding the adder; hold between records.
  always_ff @(posedge clk) begin
    if (rst) begin
      dut_a <= '0;
      dut_b <= '0;
    end else if (hs) begin
      dut_a <= rec_x;
      dut_b <= rec_y;
    end
  end

  // Record index assigned to each accepted record, saturating.
  always_ff @(posedge clk) begin
    if (rst || start_run)                idx_cnt <= '0;
    else if (hs && (idx_cnt != CNT_MAX)) idx_cnt <= idx_cnt + 1'b1;
  end

  // Compare results at the pipe tail and keep saturating statistics.
  always_ff @(posedge clk) begin
    if (rst || start_run) begin
      record_count   <= '0;
      mismatch_count <= '0;
      first_fail_idx <= '0;
      fail_seen      <= 1'b0;
    end else if (tail_valid) begin
      if (record_count != CNT_MAX) record_count <= record_count + 1'b1;
      if (bad) begin
        if (mismatch_count != CNT_MAX) mismatch_count <= mismatch_count + 1'b1;
        if (!fail_seen) begin
          fail_seen      <= 1'b1;
          first_fail_idx <= tail_idx;
        end
      end
    end
  end

endmodule
